// File: rtl/map_ss_seq.sv
// Save-state sequencer: copies a mapper's save-state registers to memory (save)
// or restores them from memory after confirming the stored mapper index (load).
module map_ss_seq #(
  parameter int          SS_LEN   = 128,
  parameter logic [23:0] MEM_BASE = 24'h000000,
  parameter int          IDX_ADDR = 127
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        m2,
  input  logic        start_save,
  input  logic        start_load,
  input  logic [7:0]  ss_rdat,
  output logic        ss_act,
  output logic        ss_we,
  output logic [7:0]  ss_addr,
  output logic [7:0]  ss_wdat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] S_RD   = 4'd1;
  localparam logic [3:0] S_MEM  = 4'd2;
  localparam logic [3:0] L_IDX  = 4'd3;
  localparam logic [3:0] L_CHK  = 4'd4;
  localparam logic [3:0] L_MEM  = 4'd5;
  localparam logic [3:0] L_WR   = 4'd6;
  localparam logic [3:0] L_WAIT = 4'd7;
  localparam logic [3:0] FIN    = 4'd8;

  localparam logic [7:0] LAST_IDX = 8'(SS_LEN - 1);
  localparam logic [7:0] IDX_A    = 8'(IDX_ADDR);

  logic [3:0] state_reg, state_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] mem_dout_reg, mem_dout_next;
  logic [7:0] chk_reg, chk_next;
  logic [7:0] ss_wdat_reg, ss_wdat_next;
  logic       err_reg, err_next;
  logic [1:0] wr_cnt_reg, wr_cnt_next;
  logic [1:0] m2_sync_reg;
  logic       m2_prev_reg;
  logic       m2_fall;

  // m2_sync_reg[1] is the synchronized m2; m2_prev_reg lags it by one cycle
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      m2_sync_reg <= 2'b00;
      m2_prev_reg <= 1'b0;
    end else begin
      m2_sync_reg <= {m2_sync_reg[0], m2};
      m2_prev_reg <= m2_sync_reg[1];
    end
  end

  assign m2_fall = m2_prev_reg & ~m2_sync_reg[1];

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    mem_dout_next = mem_dout_reg;
    chk_next      = chk_reg;
    ss_wdat_next  = ss_wdat_reg;
    err_next      = err_reg;
    wr_cnt_next   = wr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_save) begin
          state_next = S_RD;
          idx_next   = 8'd0;
          err_next   = 1'b0;
        end else if (start_load) begin
          state_next = L_IDX;
          err_next   = 1'b0;
        end
      end
      S_RD: begin
        mem_dout_next = ss_rdat;
        state_next    = S_MEM;
      end
      S_MEM: begin
        if (mem_ack) begin
          if (idx_reg == LAST_IDX) begin
            state_next = FIN;
          end else begin
            idx_next   = idx_reg + 8'd1;
            state_next = S_RD;
          end
        end
      end
      L_IDX: begin
        if (mem_ack) begin
          chk_next   = mem_din;
          state_next = L_CHK;
        end
      end
      L_CHK: begin
        if (chk_reg != ss_rdat) begin
          err_next   = 1'b1;
          state_next = FIN;
        end else begin
          idx_next   = 8'd0;
          state_next = L_MEM;
        end
      end
      L_MEM: begin
        if (mem_ack) begin
          ss_wdat_next = mem_din;
          wr_cnt_next  = 2'd0;
          state_next   = L_WR;
        end
      end
      L_WR: begin
        // The first two cycles only see falls that began before ss_we rose
        if (wr_cnt_reg == 2'd2) begin
          if (m2_fall) state_next = L_WAIT;
        end else begin
          wr_cnt_next = wr_cnt_reg + 2'd1;
        end
      end
      L_WAIT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = FIN;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = L_MEM;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      idx_reg      <= 8'd0;
      mem_dout_reg <= 8'd0;
      chk_reg      <= 8'd0;
      ss_wdat_reg  <= 8'd0;
      err_reg      <= 1'b0;
      wr_cnt_reg   <= 2'd0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      mem_dout_reg <= mem_dout_next;
      chk_reg      <= chk_next;
      ss_wdat_reg  <= ss_wdat_next;
      err_reg      <= err_next;
      wr_cnt_reg   <= wr_cnt_next;
    end
  end

  // Outputs decode from registered state so a reset clears them at once
  always_comb begin
    ss_act   = (state_reg != IDLE) && (state_reg != FIN);
    ss_we    = (state_reg == L_WR);
    ss_addr  = 8'd0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = 24'd0;
    case (state_reg)
      S_RD, L_WR, L_WAIT: ss_addr = idx_reg;
      S_MEM: begin
        ss_addr  = idx_reg;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = MEM_BASE + {16'h0000, idx_reg};
      end
      L_MEM: begin
        ss_addr  = idx_reg;
        mem_req  = 1'b1;
        mem_addr = MEM_BASE + {16'h0000, idx_reg};
      end
      L_IDX: begin
        ss_addr  = IDX_A;
        mem_req  = 1'b1;
        mem_addr = MEM_BASE + {16'h0000, IDX_A};
      end
      L_CHK:   ss_addr = IDX_A;
      default: ss_addr = 8'd0;
    endcase
  end

  assign ss_wdat  = ss_wdat_reg;
  assign mem_dout = mem_dout_reg;
  assign busy     = ss_act;
  assign done     = (state_reg == FIN);
  assign err      = err_reg;

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: mapper and memory models with randomized contents and
// ack latencies; final images are compared against array-level expectations.
module tb_map_ss_seq;

  localparam int SS_LEN   = 128;
  localparam int IDX_ADDR = 127;

  logic        clk, sys_rst, m2, start_save, start_load;
  logic [7:0]  ss_rdat, ss_addr, ss_wdat, mem_dout, mem_din;
  logic        ss_act, ss_we, mem_req, mem_we, mem_ack, busy, done, err;
  logic [23:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] map_regs [256];
  logic [7:0] mem_arr  [256];
  logic [7:0] exp_img  [256];
  logic [7:0] wr_log [$];
  logic [7:0] rd_log [$];

  int ack_delay   = 3;
  bit rand_ack    = 0;
  bit stab_en     = 1;
  bit we_chk_en   = 1;
  int done_cycles = 0;
  int we_pulses   = 0;
  int falls_total = 0;

  map_ss_seq #(.SS_LEN(SS_LEN), .MEM_BASE(24'h000000), .IDX_ADDR(IDX_ADDR)) dut (
    .clk(clk), .sys_rst(sys_rst), .m2(m2), .start_save(start_save), .start_load(start_load),
    .ss_rdat(ss_rdat), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  assign ss_rdat = map_regs[ss_addr];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // m2 period is 7 clocks, edges kept 2 ns away from clk rising edges
  initial begin
    m2 = 0;
    #3;
    forever begin
      m2 = 1; #40;
      m2 = 0; #30;
    end
  end

  always @(negedge m2) if (ss_we) falls_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder, mapper write port, done counter and ss_we span tracking
  initial begin : model
    int wait_cnt, cur_delay, rise_mark;
    logic prev_req, prev_ack, prev_we_s;
    logic [23:0] prev_addr;
    logic [7:0] prev_dout;
    wait_cnt = 0; cur_delay = 0; rise_mark = 0;
    prev_req = 0; prev_ack = 0; prev_we_s = 0; prev_addr = 0; prev_dout = 0;
    mem_ack = 0; mem_din = 0;
    forever begin
      @(posedge clk); #1;
      if (stab_en && prev_req && !prev_ack) begin
        check("stall_req", mem_req, 1'b1);
        check("stall_addr", mem_addr, prev_addr);
        check("stall_dout", mem_dout, prev_dout);
      end
      if (done) begin
        done_cycles++;
        check("done_busy", busy, 1'b0);
      end
      if (ss_we && !prev_we_s) begin
        we_pulses++;
        rise_mark = falls_total;
      end
      if (!ss_we && prev_we_s && we_chk_en) check("we_span", falls_total > rise_mark, 1'b1);
      if (ss_act && ss_we) map_regs[ss_addr] = ss_wdat;
      mem_ack = 0;
      prev_ack = 0;
      if (mem_req) begin
        if (wait_cnt == 0) cur_delay = rand_ack ? int'($urandom_range(0, 4)) : ack_delay;
        if (wait_cnt >= cur_delay) begin
          check("addr_range", mem_addr < 24'(SS_LEN), 1'b1);
          if (mem_we) begin
            mem_arr[mem_addr[7:0]] = mem_dout;
            wr_log.push_back(mem_addr[7:0]);
          end else begin
            mem_din = mem_arr[mem_addr[7:0]];
            rd_log.push_back(mem_addr[7:0]);
          end
          mem_ack = 1;
          prev_ack = 1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      prev_req = mem_req;
      prev_addr = mem_addr;
      prev_dout = mem_dout;
      prev_we_s = ss_we;
    end
  end

  task automatic pulse_start(input logic s, input logic l);
    start_save = s;
    start_load = l;
    @(negedge clk);
    start_save = 0;
    start_load = 0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cycles;
    int n = 0;
    while (done_cycles == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("timeout", n < budget, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ss_act"}, ss_act, 1'b0);
    check({pfx, "_ss_we"}, ss_we, 1'b0);
    check({pfx, "_ss_addr"}, ss_addr, 8'h00);
    check({pfx, "_ss_wdat"}, ss_wdat, 8'h00);
    check({pfx, "_mem_req"}, mem_req, 1'b0);
    check({pfx, "_mem_we"}, mem_we, 1'b0);
    check({pfx, "_mem_addr"}, mem_addr, 24'h0);
    check({pfx, "_mem_dout"}, mem_dout, 8'h00);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_err"}, err, 1'b0);
  endtask

  function automatic int diff_mem();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== exp_img[i]) d++;
    return d;
  endfunction

  function automatic int diff_map();
    int d = 0;
    for (int i = 0; i < 256; i++) if (map_regs[i] !== exp_img[i]) d++;
    return d;
  endfunction

  function automatic int save_order_errs();
    int d = 0;
    if (wr_log.size() != SS_LEN) d++;
    for (int i = 0; i < wr_log.size(); i++) if (int'(wr_log[i]) != i) d++;
    return d;
  endfunction

  function automatic int load_order_errs();
    int d = 0;
    if (rd_log.size() != SS_LEN + 1) d++;
    if (rd_log.size() > 0 && int'(rd_log[0]) != IDX_ADDR) d++;
    for (int i = 1; i < rd_log.size(); i++) if (int'(rd_log[i]) != i - 1) d++;
    return d;
  endfunction

  initial begin : stim
    int d0, w0, n, match;
    longint t0;
    sys_rst = 1;
    start_save = 0;
    start_load = 0;
    for (int i = 0; i < 256; i++) begin
      map_regs[i] = 8'hFF;
      mem_arr[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_zero("rst");
    sys_rst = 0;
    @(negedge clk);
    check_zero("idle");

    // Save with the reference mapper image
    map_regs[0] = 8'hA5; map_regs[1] = 8'h01; map_regs[127] = 8'hE2;
    for (int i = 0; i < 256; i++) exp_img[i] = (i < SS_LEN) ? map_regs[i] : mem_arr[i];
    wr_log.delete(); rd_log.delete();
    d0 = done_cycles;
    pulse_start(1, 0);
    wait_done(20000);
    check("save_mem0", mem_arr[0], 8'hA5);
    check("save_mem1", mem_arr[1], 8'h01);
    check("save_mem127", mem_arr[127], 8'hE2);
    check("save_image", diff_mem(), 0);
    check("save_order", save_order_errs(), 0);
    check("save_done", done_cycles - d0, 1);
    check("save_err", err, 1'b0);
    $display("txn save: %0d writes, done pulses %0d", wr_log.size(), done_cycles - d0);

    // Load with matching index
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'($urandom);
      map_regs[i] = 8'($urandom);
    end
    mem_arr[0] = 8'h3C; mem_arr[1] = 8'h01; mem_arr[127] = 8'hE2; map_regs[127] = 8'hE2;
    for (int i = 0; i < 256; i++) exp_img[i] = (i < SS_LEN) ? mem_arr[i] : map_regs[i];
    wr_log.delete(); rd_log.delete();
    d0 = done_cycles; w0 = we_pulses;
    pulse_start(0, 1);
    wait_done(20000);
    check("load_reg0", map_regs[0], 8'h3C);
    check("load_reg1", map_regs[1], 8'h01);
    check("load_image", diff_map(), 0);
    check("load_order", load_order_errs(), 0);
    check("load_we_pulses", we_pulses - w0, SS_LEN);
    check("load_done", done_cycles - d0, 1);
    check("load_err", err, 1'b0);
    $display("txn load: %0d reads, %0d mapper writes", rd_log.size(), we_pulses - w0);

    // Load with mismatching index
    mem_arr[127] = 8'h10; map_regs[127] = 8'hE2;
    for (int i = 0; i < 256; i++) exp_img[i] = map_regs[i];
    rd_log.delete();
    d0 = done_cycles; w0 = we_pulses;
    pulse_start(0, 1);
    wait_done(2000);
    check("mis_err", err, 1'b1);
    check("mis_we", we_pulses - w0, 0);
    check("mis_done", done_cycles - d0, 1);
    check("mis_image", diff_map(), 0);
    check("mis_reads", rd_log.size(), 1);
    repeat (5) @(negedge clk);
    check("mis_err_hold", err, 1'b1);
    $display("txn load-mismatch: err=%0d", err);

    // Simultaneous starts, then a load during busy
    for (int i = 0; i < 256; i++) exp_img[i] = (i < SS_LEN) ? map_regs[i] : mem_arr[i];
    wr_log.delete(); rd_log.delete();
    d0 = done_cycles; w0 = we_pulses;
    pulse_start(1, 1);
    check("both_err_clr", err, 1'b0);
    check("both_busy", busy, 1'b1);
    repeat (5) @(negedge clk);
    pulse_start(0, 1);
    wait_done(20000);
    repeat (20) @(negedge clk);
    check("both_writes", wr_log.size(), SS_LEN);
    check("both_reads", rd_log.size(), 0);
    check("both_we", we_pulses - w0, 0);
    check("both_done", done_cycles - d0, 1);
    check("both_image", diff_mem(), 0);
    check("both_idle", busy, 1'b0);
    $display("txn save(both): %0d writes, done pulses %0d", wr_log.size(), done_cycles - d0);

    // Randomized save/load rounds with random ack latency
    rand_ack = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem_arr[i] = 8'($urandom);
        map_regs[i] = 8'($urandom);
      end
      match = int'($urandom_range(0, 1));
      mem_arr[127] = (match != 0) ? map_regs[127] : (map_regs[127] ^ 8'(1 + $urandom_range(0, 254)));
      d0 = done_cycles;
      if (r % 2 == 0) begin
        for (int i = 0; i < 256; i++) exp_img[i] = (i < SS_LEN) ? map_regs[i] : mem_arr[i];
        pulse_start(1, 0);
        wait_done(20000);
        check("rnd_save_image", diff_mem(), 0);
        check("rnd_save_err", err, 1'b0);
      end else begin
        for (int i = 0; i < 256; i++)
          exp_img[i] = (match != 0 && i < SS_LEN) ? mem_arr[i] : map_regs[i];
        pulse_start(0, 1);
        wait_done(20000);
        check("rnd_load_image", diff_map(), 0);
        check("rnd_load_err", err, (match != 0) ? 1'b0 : 1'b1);
      end
      check("rnd_done", done_cycles - d0, 1);
      $display("txn random round %0d: %s, index match %0d, err=%0d", r,
               (r % 2 == 0) ? "save" : "load", match, err);
    end
    rand_ack = 0;

    // Reset in the middle of a load at idx 40
    ack_delay = 1;
    mem_arr[127] = map_regs[127];
    pulse_start(0, 1);
    n = 0;
    while (!(ss_we && ss_addr == 8'd40) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx40", n < 30000, 1'b1);
    we_chk_en = 0;
    stab_en = 0;
    d0 = done_cycles;
    #2 sys_rst = 1;
    #1 check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    sys_rst = 0;
    repeat (3) @(negedge clk);
    check("midrst_nodone", done_cycles - d0, 0);
    check("midrst_idle", busy, 1'b0);
    we_chk_en = 1;
    stab_en = 1;
    wr_log.delete();
    pulse_start(1, 0);
    wait_done(20000);
    check("post_rst_first", (wr_log.size() > 0) ? int'(wr_log[0]) : -1, 0);
    check("post_rst_order", save_order_errs(), 0);
    $display("txn reset at idx 40, then save: %0d writes", wr_log.size());

    // Stalled memory: ack withheld 50 cycles on every write
    ack_delay = 50;
    for (int i = 0; i < 256; i++) exp_img[i] = (i < SS_LEN) ? map_regs[i] : mem_arr[i];
    d0 = done_cycles;
    t0 = $time;
    pulse_start(1, 0);
    wait_done(20000);
    check("stall_len", ($time - t0) >= longint'(SS_LEN * 50 * 10), 1'b1);
    check("stall_image", diff_mem(), 0);
    check("stall_done", done_cycles - d0, 1);
    $display("txn stalled save: %0d ns", $time - t0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
